// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO edge/interrupt stage: register selects and default width.
// GPIO_DEBOUNCE_EN (when defined) compiles the per-pin debounce counters into gpio_debounce.
package gpio_pkg;

    localparam int GPIO_WIDTH           = 16;
    localparam int GPIO_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        REG_RISE_EN = 2'b00,
        REG_FALL_EN = 2'b01,
        REG_PENDING = 2'b10,
        REG_STATE   = 2'b11
    } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin two-flop synchronizer followed by the filtered-level register.
// With GPIO_DEBOUNCE_EN defined, a level is accepted only after DEBOUNCE_CYCLES stable cycles.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_filtered
);

    logic r_sync1;
    logic r_sync2;
    logic r_filtered;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_filtered <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filtered) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_filtered <= r_sync2;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (DEBOUNCE_CYCLES != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_filtered <= 1'b0;
        end else begin
            r_sync1    <= i_pin;
            r_sync2    <= r_sync1;
            r_filtered <= r_sync2;
        end
    end
`endif

    assign o_filtered = r_filtered;

endmodule

// File: rtl/module_gpio_edge_irq.sv
// GPIO input conditioning, per-pin edge detection, W1C pending register and level interrupt.
// Debounce is compiled in only when GPIO_DEBOUNCE_EN is defined.
module module_gpio_edge_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       reg_sel,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic [WIDTH-1:0] filtered,
    output logic             irq
);

    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] r_filtered_d;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_dout;
    logic             w_unused_din;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .i_pin      (pins_in[i]),
            .o_filtered (w_filtered[i])
        );
    end

    assign w_wdata      = din[WIDTH-1:0];
    assign w_unused_din = ^din;

    assign w_rise = w_filtered & ~r_filtered_d;
    assign w_fall = ~w_filtered & r_filtered_d;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (we && reg_sel == REG_PENDING) ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filtered_d <= '0;
            r_rise_en    <= '0;
            r_fall_en    <= '0;
            r_pending    <= '0;
        end else begin
            r_filtered_d <= w_filtered;
            if (we && reg_sel == REG_RISE_EN) r_rise_en <= w_wdata;
            if (we && reg_sel == REG_FALL_EN) r_fall_en <= w_wdata;
            // A new edge on the same cycle as its W1C keeps the bit set.
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_dout = '0;
        case (reg_sel)
            REG_RISE_EN: w_dout[WIDTH-1:0] = r_rise_en;
            REG_FALL_EN: w_dout[WIDTH-1:0] = r_fall_en;
            REG_PENDING: w_dout[WIDTH-1:0] = r_pending;
            default:     w_dout[WIDTH-1:0] = w_filtered;
        endcase
    end

    assign dout     = w_dout;
    assign filtered = w_filtered;
    assign irq      = |r_pending;

endmodule
